// File: rtl/div_pkg.sv
// div_pkg: shared types and helpers for the handshaked radix-2 divider.
// Contents: FSM state enum, absolute-value helper used at operand capture.
// No ports; imported by divider_signed_hs.
package div_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIX,
    S_DONE
  } div_state_t;

  // Widest operand the helper below can serve; callers zero-extend into it
  // and keep only their own low WIDTH bits of the result.
  localparam int unsigned ABS_MAX_W = 64;

  // Two's-complement negate when neg is set. Negating a zero-extended value
  // and truncating back gives the WIDTH-bit magnitude, including MIN whose
  // magnitude 2^(WIDTH-1) comes out as the unsigned pattern of MIN itself.
  function automatic logic [ABS_MAX_W-1:0] abs_if_signed(
    input logic [ABS_MAX_W-1:0] v,
    input logic                 neg
  );
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division step (one quotient bit).
// Ports: acc_i/quo_i/divisor_i current partial remainder, dividend shift
//   register and divisor; acc_o/quo_o their values after the step.
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   acc_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   acc_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] acc_sh;
  logic [WIDTH:0] div_ext;
  // The stored remainder is always below the divisor, so its top bit is
  // zero between steps; the extra bit only matters after the shift.
  logic           unused_acc_msb;

  assign unused_acc_msb = acc_i[WIDTH];

  always_comb begin
    acc_sh  = {acc_i[WIDTH-1:0], quo_i[WIDTH-1]};
    div_ext = {1'b0, divisor_i};
    quo_o   = {quo_i[WIDTH-2:0], 1'b0};
    acc_o   = acc_sh;
    if (acc_sh >= div_ext) begin
      acc_o    = acc_sh - div_ext;
      quo_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/divider_signed_hs.sv
// divider_signed_hs: multi-cycle signed/unsigned divider, valid/ready on both sides.
// Ports: clk/reset (sync, active-high); in_valid/in_ready/in_signed/x/y operand
//   side; out_valid/out_ready/q/r/dbz/ovf result side; busy while iterating.
module divider_signed_hs
  import div_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             dbz,
  output logic             ovf,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic             sign_q_q, sign_q_d;
  logic             sign_r_q, sign_r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;

  logic [ABS_MAX_W-1:0] x_abs_full, y_abs_full;
  logic [WIDTH-1:0]     x_abs, y_abs, rem;
  logic [WIDTH:0]       step_acc;
  logic [WIDTH-1:0]     step_quo;
  logic                 is_dbz, is_ovf, cnt_last;
  logic                 unused_bits;

  assign x_abs_full = abs_if_signed(ABS_MAX_W'(x), in_signed & x[WIDTH-1]);
  assign y_abs_full = abs_if_signed(ABS_MAX_W'(y), in_signed & y[WIDTH-1]);
  assign x_abs      = x_abs_full[WIDTH-1:0];
  assign y_abs      = y_abs_full[WIDTH-1:0];
  assign rem        = acc_q[WIDTH-1:0];
  assign unused_bits = ^{x_abs_full, y_abs_full, acc_q[WIDTH]};

  assign is_dbz   = (y == '0);
  assign is_ovf   = in_signed && (x == MIN_VAL) && (&y);
  assign cnt_last = (cnt_q == CNT_W'(WIDTH - 1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .acc_i     (acc_q),
    .quo_i     (quo_q),
    .divisor_i (div_q),
    .acc_o     (step_acc),
    .quo_o     (step_quo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    quo_d    = quo_q;
    div_d    = div_q;
    sign_q_d = sign_q_q;
    sign_r_d = sign_r_q;
    q_d      = q_q;
    r_d      = r_q;
    dbz_d    = dbz_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_dbz) begin
            q_d     = '0;
            r_d     = x;
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = S_DONE;
          end else if (is_ovf) begin
            q_d     = MIN_VAL;
            r_d     = '0;
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            acc_d    = '0;
            quo_d    = x_abs;
            div_d    = y_abs;
            sign_q_d = in_signed & (x[WIDTH-1] ^ y[WIDTH-1]);
            sign_r_d = in_signed & x[WIDTH-1];
            cnt_d    = '0;
            state_d  = S_CALC;
          end
        end
      end
      S_CALC: begin
        acc_d = step_acc;
        quo_d = step_quo;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_last) state_d = S_FIX;
      end
      S_FIX: begin
        // Truncating division: quotient sign from operand signs, remainder
        // follows the dividend.
        q_d     = sign_q_q ? -quo_q : quo_q;
        r_d     = sign_r_q ? -rem : rem;
        dbz_d   = 1'b0;
        ovf_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      q_q      <= '0;
      r_q      <= '0;
      dbz_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      sign_q_q <= sign_q_d;
      sign_r_q <= sign_r_d;
      q_q      <= q_d;
      r_q      <= r_d;
      dbz_q    <= dbz_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q == S_CALC) || (state_q == S_FIX);
  assign q         = q_q;
  assign r         = r_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_divider_signed_hs.sv
// tb_divider_signed_hs: self-checking bench, WIDTH=8 vector table and corner
// sequences plus a WIDTH=16 randomized sweep against an arithmetic model.
// No ports.
module tb_divider_signed_hs;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // WIDTH=8 instance
  logic       a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready;
  logic [7:0] a_x, a_y, a_q, a_r;
  logic       a_dbz, a_ovf, a_busy;

  // WIDTH=16 instance
  logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready;
  logic [15:0] b_x, b_y, b_q, b_r;
  logic        b_dbz, b_ovf, b_busy;

  divider_signed_hs #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_signed(a_in_signed),
    .x(a_x), .y(a_y),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .q(a_q), .r(a_r), .dbz(a_dbz), .ovf(a_ovf), .busy(a_busy)
  );

  divider_signed_hs #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_signed(b_in_signed),
    .x(b_x), .y(b_y),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .q(b_q), .r(b_r), .dbz(b_dbz), .ovf(b_ovf), .busy(b_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    bit         sgn;
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] eq;
    logic [7:0] er;
    bit         edz;
    bit         eov;
    int         elat;
  } vec_t;

  // Reference: plain integer arithmetic on sign- or zero-extended operands.
  function automatic void ref16(input bit sgn, input logic [15:0] xv, input logic [15:0] yv,
                                output logic [15:0] qo, output logic [15:0] ro,
                                output logic dz, output logic ov);
    longint sx, sy;
    dz = 1'b0;
    ov = 1'b0;
    if (yv == 16'd0) begin
      dz = 1'b1; qo = 16'd0; ro = xv;
      return;
    end
    if (sgn) begin
      sx = longint'($signed(xv));
      sy = longint'($signed(yv));
      if (sx == -32768 && sy == -1) begin
        ov = 1'b1; qo = 16'h8000; ro = 16'd0;
        return;
      end
    end else begin
      sx = longint'(xv);
      sy = longint'(yv);
    end
    qo = 16'(sx / sy);
    ro = 16'(sx % sy);
  endfunction

  // One 8-bit operation; lat = cycles from accept to first out_valid.
  task automatic run8(input bit sgn, input logic [7:0] xv, input logic [7:0] yv, input int hold,
                      output logic [7:0] qo, output logic [7:0] ro,
                      output logic dz, output logic ov, output int lat);
    bit rdy_seen;
    rdy_seen = 1'b0;
    lat = 0;
    @(negedge clk);
    check("in_ready_before_op", a_in_ready, 1);
    a_in_valid = 1'b1; a_in_signed = sgn; a_x = xv; a_y = yv;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0; a_x = 8'($urandom); a_y = 8'($urandom);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (a_out_valid) begin lat = c; break; end
      if (a_in_ready) rdy_seen = 1'b1;
    end
    check("in_ready_low_while_busy", rdy_seen, 0);
    qo = a_q; ro = a_r; dz = a_dbz; ov = a_ovf;
    repeat (hold) @(negedge clk);
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0;
    @(negedge clk);
    check("in_ready_after_handshake", a_in_ready, 1);
    check("out_valid_after_handshake", a_out_valid, 0);
  endtask

  task automatic run16(input bit sgn, input logic [15:0] xv, input logic [15:0] yv, input int hold,
                       output logic [15:0] qo, output logic [15:0] ro,
                       output logic dz, output logic ov, output int lat);
    lat = 0;
    @(negedge clk);
    b_in_valid = 1'b1; b_in_signed = sgn; b_x = xv; b_y = yv;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (b_out_valid) begin lat = c; break; end
    end
    qo = b_q; ro = b_r; dz = b_dbz; ov = b_ovf;
    repeat (hold) @(negedge clk);
    b_out_ready = 1'b1;
    @(posedge clk);
    #1;
    b_out_ready = 1'b0;
  endtask

  vec_t       vecs[11];
  logic [7:0] gq, gr, hq, hr;
  logic       gdz, gov, hdz, hov;
  int         glat;
  bit         seen;

  initial begin
    vecs[0]  = '{1'b0, 8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 1'b0, 10};
    vecs[1]  = '{1'b1, 8'hF9,  8'd2,   8'hFD,  8'hFF,  1'b0, 1'b0, 10};
    vecs[2]  = '{1'b1, 8'd7,   8'hFE,  8'hFD,  8'h01,  1'b0, 1'b0, 10};
    vecs[3]  = '{1'b1, 8'h80,  8'd3,   8'hD6,  8'hFE,  1'b0, 1'b0, 10};
    vecs[4]  = '{1'b0, 8'd5,   8'd0,   8'd0,   8'd5,   1'b1, 1'b0, 1};
    vecs[5]  = '{1'b1, 8'd5,   8'd0,   8'd0,   8'd5,   1'b1, 1'b0, 1};
    vecs[6]  = '{1'b1, 8'h80,  8'hFF,  8'h80,  8'd0,   1'b0, 1'b1, 1};
    vecs[7]  = '{1'b0, 8'd128, 8'd255, 8'd0,   8'd128, 1'b0, 1'b0, 10};
    vecs[8]  = '{1'b0, 8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 1'b0, 10};
    vecs[9]  = '{1'b1, 8'h80,  8'd1,   8'h80,  8'd0,   1'b0, 1'b0, 10};
    vecs[10] = '{1'b0, 8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 1'b0, 10};

    reset = 1'b1;
    a_in_valid = 1'b0; a_in_signed = 1'b0; a_x = '0; a_y = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_signed = 1'b0; b_x = '0; b_y = '0; b_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", a_in_ready, 1);
    check("reset_out_valid", a_out_valid, 0);
    check("reset_busy", a_busy, 0);
    check("reset_q_r_flags", {a_q, a_r, a_dbz, a_ovf}, 0);
    reset = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 11; i++) begin
      run8(vecs[i].sgn, vecs[i].x, vecs[i].y, i % 3, gq, gr, gdz, gov, glat);
      check($sformatf("vec%0d_q", i), gq, vecs[i].eq);
      check($sformatf("vec%0d_r", i), gr, vecs[i].er);
      check($sformatf("vec%0d_dbz", i), gdz, vecs[i].edz);
      check($sformatf("vec%0d_ovf", i), gov, vecs[i].eov);
      check($sformatf("vec%0d_latency", i), glat, vecs[i].elat);
    end

    // Backpressure: result held for 5 stalled cycles, new requests ignored
    @(negedge clk);
    a_in_valid = 1'b1; a_in_signed = 1'b0; a_x = 8'd100; a_y = 8'd9;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (a_out_valid) begin seen = 1'b1; break; end
    end
    check("bp_out_valid_reached", seen, 1);
    hq = a_q; hr = a_r; hdz = a_dbz; hov = a_ovf;
    check("bp_result", {hq, hr, hdz, hov}, {8'd11, 8'd1, 1'b0, 1'b0});
    for (int c = 0; c < 5; c++) begin
      a_in_valid = 1'b1; a_x = 8'($urandom); a_y = 8'd0; a_in_signed = 1'($urandom);
      @(negedge clk);
      check($sformatf("bp_hold%0d", c), {a_q, a_r, a_dbz, a_ovf, a_out_valid, a_in_ready},
            {hq, hr, hdz, hov, 1'b1, 1'b0});
    end
    a_out_ready = 1'b1;
    @(posedge clk);
    #1;
    a_out_ready = 1'b0; a_in_valid = 1'b0;
    @(negedge clk);
    check("bp_release_in_ready", a_in_ready, 1);
    check("bp_release_out_valid", a_out_valid, 0);
    check("bp_idle_keeps_result", {a_q, a_r}, {8'd11, 8'd1});

    // Reset pulse mid-CALC
    @(negedge clk);
    a_in_valid = 1'b1; a_in_signed = 1'b0; a_x = 8'd200; a_y = 8'd7;
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(negedge clk);
    check("midcalc_busy", a_busy, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("after_reset_in_ready", a_in_ready, 1);
    check("after_reset_busy", a_busy, 0);
    check("after_reset_out_valid", a_out_valid, 0);
    check("after_reset_outputs", {a_q, a_r, a_dbz, a_ovf}, 0);
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (a_out_valid) seen = 1'b1;
    end
    check("no_result_after_reset", seen, 0);
    run8(1'b0, 8'd100, 8'd9, 0, gq, gr, gdz, gov, glat);
    check("post_reset_100_9", {gq, gr, gdz, gov}, {8'd11, 8'd1, 1'b0, 1'b0});
    check("post_reset_latency", glat, 10);

    // WIDTH=16 randomized sweep
    for (int i = 0; i < 300; i++) begin
      bit          sgn;
      logic [15:0] xv, yv, eq, er, oq, orr;
      logic        edz, eov, odz, oov;
      int          olat;
      sgn = 1'($urandom);
      xv  = 16'($urandom);
      yv  = 16'($urandom);
      case ($urandom_range(0, 9))
        0: yv = 16'd0;
        1: begin sgn = 1'b1; xv = 16'h8000; yv = 16'hFFFF; end
        2: yv = 16'($urandom_range(1, 5));
        3: xv = 16'h8000;
        4: yv = 16'hFFFF;
        default: ;
      endcase
      ref16(sgn, xv, yv, eq, er, edz, eov);
      run16(sgn, xv, yv, $urandom_range(0, 3), oq, orr, odz, oov, olat);
      check($sformatf("rnd%0d_s%0d_%0h_%0h", i, sgn, xv, yv), {oq, orr, odz, oov}, {eq, er, edz, eov});
      check($sformatf("rnd%0d_latency", i), olat, (edz || eov) ? 1 : 18);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
